// File: rtl/alu_seq_pkg.sv
// Shared types and encodings for the ALU sequencer: FSM states, instruction fields,
// datapath select encodings and ALU operation codes.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        StWait     = 3'd0,
        StDecode   = 3'd1,
        StGetA     = 3'd2,
        StGetB     = 3'd3,
        StOperate  = 3'd4,
        StWriteReg = 3'd5,
        StWriteImm = 3'd6
    } state_e;

    localparam logic [2:0] OPC_MOV = 3'b110;
    localparam logic [2:0] OPC_ALU = 3'b101;

    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [2:0] NSEL_NONE = 3'b000;
    localparam logic [2:0] NSEL_RN   = 3'b001;
    localparam logic [2:0] NSEL_RD   = 3'b010;
    localparam logic [2:0] NSEL_RM   = 3'b100;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

endpackage

// File: rtl/alu_seq_decode.sv
// Instruction decoder: maps the latched {opcode, op} to the state that follows DECODE
// and flags instructions outside the supported set.
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [2:0] i_opcode,
    input  logic [1:0] i_op,
    output state_e     o_next_state,
    output logic       o_illegal
);

    always_comb begin
        o_next_state = StWait;
        o_illegal    = 1'b0;
        case ({i_opcode, i_op})
            {OPC_MOV, OP_MOV_IMM}: o_next_state = StWriteImm;
            {OPC_MOV, OP_MOV_REG}: o_next_state = StGetB;
            {OPC_ALU, OP_MVN}:     o_next_state = StGetB;
            {OPC_ALU, OP_ADD},
            {OPC_ALU, OP_CMP},
            {OPC_ALU, OP_AND}:     o_next_state = StGetA;
            default: begin
                o_next_state = StWait;
                o_illegal    = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Moore FSM sequencing register file, A/B/C registers, status and ALU per instruction.
// Optional retired-instruction counter enabled by defining SEQ_PERF_EN.
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int STATE_W = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s,
    input  logic [2:0]       opcode,
    input  logic [1:0]       op,
    output logic             w,
    output logic [2:0]       nsel,
    output logic [1:0]       vsel,
    output logic             loada,
    output logic             loadb,
    output logic             asel,
    output logic             bsel,
    output logic [1:0]       ALUop,
    output logic             loadc,
    output logic             loads,
    output logic             write,
    output logic             illegal,
    output logic [CNT_W-1:0] instr_count
);

    state_e     r_state;
    state_e     w_next_state;
    state_e     w_dec_next;
    logic       w_dec_illegal;
    logic [2:0] r_opcode;
    logic [1:0] r_op;
    logic       w_is_cmp;
    logic       w_retire;

    // Instruction fields are captured only on the start edge so the inputs may change in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StWait;
            r_opcode <= 3'b000;
            r_op     <= 2'b00;
        end else begin
            r_state <= w_next_state;
            if (r_state == StWait && s) begin
                r_opcode <= opcode;
                r_op     <= op;
            end
        end
    end

    alu_seq_decode u_decode (
        .i_opcode     (r_opcode),
        .i_op         (r_op),
        .o_next_state (w_dec_next),
        .o_illegal    (w_dec_illegal)
    );

    assign w_is_cmp = (r_opcode == OPC_ALU) && (r_op == OP_CMP);

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            StWait:     w_next_state = s ? StDecode : StWait;
            StDecode:   w_next_state = w_dec_next;
            StGetA:     w_next_state = StGetB;
            StGetB:     w_next_state = StOperate;
            StOperate:  w_next_state = w_is_cmp ? StWait : StWriteReg;
            StWriteReg: w_next_state = StWait;
            StWriteImm: w_next_state = StWait;
            default:    w_next_state = StWait;
        endcase
    end

    always_comb begin
        w       = 1'b0;
        nsel    = NSEL_NONE;
        vsel    = VSEL_C;
        loada   = 1'b0;
        loadb   = 1'b0;
        asel    = 1'b0;
        bsel    = 1'b0;
        ALUop   = ALU_ADD;
        loadc   = 1'b0;
        loads   = 1'b0;
        write   = 1'b0;
        illegal = 1'b0;
        unique case (r_state)
            StWait:   w = 1'b1;
            StDecode: illegal = w_dec_illegal;
            StGetA: begin
                nsel  = NSEL_RN;
                loada = 1'b1;
            end
            StGetB: begin
                nsel  = NSEL_RM;
                loadb = 1'b1;
            end
            StOperate: begin
                // MOV reg passes B through the adder with A forced to zero.
                ALUop = (r_opcode == OPC_ALU) ? r_op : ALU_ADD;
                asel  = (r_opcode == OPC_MOV);
                loads = w_is_cmp;
                loadc = !w_is_cmp;
            end
            StWriteReg: begin
                nsel  = NSEL_RD;
                vsel  = VSEL_C;
                write = 1'b1;
            end
            StWriteImm: begin
                nsel  = NSEL_RN;
                vsel  = VSEL_IMM;
                write = 1'b1;
            end
            default: w = 1'b0;
        endcase
    end

    assign w_retire = (r_state == StWriteReg) || (r_state == StWriteImm) ||
                      ((r_state == StOperate) && w_is_cmp);

`ifdef SEQ_PERF_EN
    logic [CNT_W-1:0] r_instr_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instr_count <= '0;
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + 1'b1;
        end
    end

    assign instr_count = r_instr_count;
`else
    logic w_unused;
    assign w_unused    = w_retire;
    assign instr_count = '0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: directed vector table, hand-written corner
// sequences and randomized instructions against a micro-step reference model.
module tb_alu_seq_ctrl;

    localparam int CNT_W = 16;

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       asel;
        logic       bsel;
        logic [1:0] aluop;
        logic       loadc;
        logic       loads;
        logic       write;
        logic       illegal;
    } outv_t;

    typedef struct {
        logic [2:0] opc;
        logic [1:0] op;
        int         lat;
        int         ill;
        string      name;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             s;
    logic [2:0]       opcode;
    logic [1:0]       op;
    logic             w;
    logic [2:0]       nsel;
    logic [1:0]       vsel;
    logic             loada, loadb, asel, bsel, loadc, loads, write, illegal;
    logic [1:0]       ALUop;
    logic [CNT_W-1:0] instr_count;

    int    n_checks = 0;
    int    n_pass   = 0;
    int    model_cnt = 0;
    outv_t exp_q[$];
    outv_t idle_v;

    alu_seq_ctrl #(.STATE_W(3), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .s           (s),
        .opcode      (opcode),
        .op          (op),
        .w           (w),
        .nsel        (nsel),
        .vsel        (vsel),
        .loada       (loada),
        .loadb       (loadb),
        .asel        (asel),
        .bsel        (bsel),
        .ALUop       (ALUop),
        .loadc       (loadc),
        .loads       (loads),
        .write       (write),
        .illegal     (illegal),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    function automatic outv_t actual();
        outv_t a;
        a = '{w, nsel, vsel, loada, loadb, asel, bsel, ALUop, loadc, loads, write, illegal};
        return a;
    endfunction

    function automatic bit is_legal(input logic [2:0] opc, input logic [1:0] o);
        return (opc == 3'b110 && (o == 2'b10 || o == 2'b00)) || (opc == 3'b101);
    endfunction

    // Reference model: the list of busy cycles an instruction spends before returning idle.
    function automatic void build_steps(input logic [2:0] opc, input logic [1:0] o);
        outv_t st;
        exp_q.delete();
        st = '0;
        st.illegal = !is_legal(opc, o);
        exp_q.push_back(st);
        if (!is_legal(opc, o)) return;
        if (opc == 3'b110 && o == 2'b10) begin
            st = '0; st.nsel = 3'b001; st.vsel = 2'b10; st.write = 1'b1;
            exp_q.push_back(st);
            return;
        end
        if (opc == 3'b101 && o != 2'b11) begin
            st = '0; st.nsel = 3'b001; st.loada = 1'b1;
            exp_q.push_back(st);
        end
        st = '0; st.nsel = 3'b100; st.loadb = 1'b1;
        exp_q.push_back(st);
        st = '0;
        st.aluop = (opc == 3'b101) ? o : 2'b00;
        st.asel  = (opc == 3'b110);
        if (opc == 3'b101 && o == 2'b01) st.loads = 1'b1;
        else st.loadc = 1'b1;
        exp_q.push_back(st);
        if (!(opc == 3'b101 && o == 2'b01)) begin
            st = '0; st.nsel = 3'b010; st.vsel = 2'b00; st.write = 1'b1;
            exp_q.push_back(st);
        end
    endfunction

    task automatic check_v(input string name, input outv_t exp);
        outv_t a;
        a = actual();
        n_checks++;
        if (a === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, a, exp);
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    task automatic check_cnt(input string name);
        logic [CNT_W-1:0] e;
`ifdef SEQ_PERF_EN
        e = CNT_W'(model_cnt);
`else
        e = '0;
`endif
        n_checks++;
        if (instr_count === e) n_pass++;
        else $display("FAIL %s: instr_count got %0d expected %0d", name, instr_count, e);
    endtask

    // Starts at a negedge in WAIT; returns at the negedge where w is seen high again.
    task automatic run_instr(input string name, input logic [2:0] opc, input logic [1:0] o,
                             output int lat, output int ill);
        outv_t a;
        int    idx;
        bit    done;
        build_steps(opc, o);
        s = 1'b1; opcode = opc; op = o;
        @(posedge clk);
        #1;
        s = 1'b0; opcode = 3'($urandom); op = 2'($urandom);
        idx = 0; lat = 0; ill = 0; done = 1'b0;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            a = actual();
            if (idx < exp_q.size()) check_v({name, " step"}, exp_q[idx]);
            else check_v({name, " idle"}, idle_v);
            idx++;
            if (a.illegal) ill++;
            if (a.w) begin
                done = 1'b1;
                lat  = c + 1;
            end
        end
        if (!done) begin
            n_checks++;
            $display("FAIL %s timeout: w still 0 after 10 cycles, required 1", name);
        end
        if (is_legal(opc, o)) model_cnt++;
        check_cnt({name, " count"});
    endtask

    vec_t vecs[10];

    initial begin
        int lat, ill;
        logic [2:0] ropc;
        logic [1:0] rop;

        idle_v = '0;
        idle_v.w = 1'b1;
        vecs[0] = '{3'b110, 2'b10, 3, 0, "movi"};
        vecs[1] = '{3'b110, 2'b00, 5, 0, "movr"};
        vecs[2] = '{3'b101, 2'b11, 5, 0, "mvn"};
        vecs[3] = '{3'b101, 2'b00, 6, 0, "add"};
        vecs[4] = '{3'b101, 2'b01, 5, 0, "cmp"};
        vecs[5] = '{3'b101, 2'b10, 6, 0, "and"};
        vecs[6] = '{3'b111, 2'b00, 2, 1, "ill111"};
        vecs[7] = '{3'b110, 2'b01, 2, 1, "ill110_01"};
        vecs[8] = '{3'b110, 2'b11, 2, 1, "ill110_11"};
        vecs[9] = '{3'b000, 2'b00, 2, 1, "ill000"};

        reset = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00;
        repeat (2) @(negedge clk);
        check_v("reset", idle_v);
        check_cnt("reset count");
        s = 1'b1; opcode = 3'b101;
        @(negedge clk);
        check_v("reset holds with s", idle_v);
        reset = 1'b0; s = 1'b0;
        @(negedge clk);
        check_v("after reset", idle_v);

        for (int i = 0; i < 10; i++) begin
            run_instr(vecs[i].name, vecs[i].opc, vecs[i].op, lat, ill);
            check_int({vecs[i].name, " latency"}, lat, vecs[i].lat);
            check_int({vecs[i].name, " illegal pulses"}, ill, vecs[i].ill);
        end

        // s held high with an illegal instruction: decode restarts only from WAIT.
        s = 1'b1; opcode = 3'b111; op = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_v("hold-s decode", '{1'b0, 3'b0, 2'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b0,
                                       1'b0, 1'b0, 1'b0, 1'b1});
            @(negedge clk);
            check_v("hold-s wait", idle_v);
        end
        s = 1'b0;
        @(negedge clk);
        check_v("hold-s released", idle_v);

        // Reset asserted during the OPERATE cycle of an ADD.
        s = 1'b1; opcode = 3'b101; op = 2'b00;
        @(posedge clk);
        #1 s = 1'b0;
        repeat (4) @(negedge clk);
        check_int("add operate loadc", int'(loadc), 1);
        reset = 1'b1;
        #1;
        check_v("reset mid-operate", idle_v);
        @(negedge clk);
        check_v("reset held", idle_v);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_v("post-abort idle", idle_v);
        end
        check_cnt("abort not counted");

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                ropc = vecs[$urandom_range(0, 5)].opc;
                rop  = vecs[$urandom_range(0, 5)].op;
                ropc = ($urandom_range(0, 1) == 0) ? 3'b101 : ropc;
            end else begin
                ropc = 3'($urandom);
                rop  = 2'($urandom);
            end
            run_instr("rand", ropc, rop, lat, ill);
            if ($urandom_range(0, 3) == 0) begin
                s = 1'b0; opcode = 3'($urandom); op = 2'($urandom);
                @(negedge clk);
                check_v("rand gap idle", idle_v);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
